// File: rtl/chip8_sprite_blitter.sv
// CHIP-8/SCHIP display engine: XOR-blits fetched sprite rows into a WIDTHxHEIGHT framebuffer, with a row-per-cycle clear.
// Latency: draw 2*rows+1 cycles with zero-wait memory, clear HEIGHT+1; cmd_ready only in IDLE (no queueing); row fetch stalls freely.
module chip8_sprite_blitter #(
    parameter int WIDTH    = 64,
    parameter int HEIGHT   = 32,
    parameter int SPRITE_W = 8,
    parameter int MAX_ROWS = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_op,
    input  logic [$clog2(WIDTH)-1:0]      cmd_x,
    input  logic [$clog2(HEIGHT)-1:0]     cmd_y,
    input  logic [$clog2(MAX_ROWS):0]     cmd_rows,
    input  logic                          wrap_mode,
    output logic                          row_req,
    output logic [$clog2(MAX_ROWS)-1:0]   row_index,
    input  logic [SPRITE_W-1:0]           row_data,
    input  logic                          row_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          collision,
    output logic [WIDTH*HEIGHT-1:0]       display
);

    localparam int XW  = $clog2(WIDTH);
    localparam int YW  = $clog2(HEIGHT);
    localparam int RW  = $clog2(MAX_ROWS) + 1;
    localparam int IW  = $clog2(MAX_ROWS);
    localparam int SWB = $clog2(SPRITE_W);
    localparam int PXW = ((XW > SWB) ? XW : SWB) + 1;
    localparam int PYW = ((YW > RW) ? YW : RW) + 1;

    localparam logic [PXW-1:0] WIDTH_P  = PXW'(WIDTH);
    localparam logic [PYW-1:0] HEIGHT_P = PYW'(HEIGHT);
    localparam logic [YW-1:0]  LAST_ROW = YW'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [RW-1:0] rows;
        logic          wrap;
    } cmd_t;

    state_t                         state_q, state_d;
    cmd_t                           cmd_q, cmd_d;
    logic [RW-1:0]                  r_q, r_d;
    logic [YW-1:0]                  clr_row_q, clr_row_d;
    logic [SPRITE_W-1:0]            row_dat_q, row_dat_d;
    logic                           acc_q, acc_d;
    logic                           collision_q, collision_d;
    // Row y is stored at index HEIGHT-1-y and column x at WIDTH-1-x, so the
    // flattened vector puts pixel (0,0) in the MSB as the display port expects.
    logic [HEIGHT-1:0][WIDTH-1:0]   fb_q, fb_d;

    logic [PXW-1:0]                 px;
    logic [PYW-1:0]                 py;
    logic [PYW-1:0]                 next_y;
    logic [XW-1:0]                  pxm;
    logic [YW-1:0]                  pym;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        r_d         = r_q;
        clr_row_d   = clr_row_q;
        row_dat_d   = row_dat_q;
        acc_d       = acc_q;
        collision_d = collision_q;
        fb_d        = fb_q;
        px          = '0;
        py          = '0;
        next_y      = '0;
        pxm         = '0;
        pym         = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.x0   = cmd_x;
                    cmd_d.y0   = cmd_y;
                    cmd_d.rows = cmd_rows;
                    cmd_d.wrap = wrap_mode;
                    acc_d      = 1'b0;
                    r_d        = '0;
                    clr_row_d  = '0;
                    if (cmd_op) begin
                        state_d = S_CLEAR;
                    end else if (cmd_rows == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                if (row_valid) begin
                    row_dat_d = row_data;
                    state_d   = S_WRITE;
                end
            end

            S_WRITE: begin
                // fb_d is read back inside the loop so overlapping wrapped
                // pixels toggle and collide exactly as sequential XORs would.
                for (int i = 0; i < SPRITE_W; i++) begin
                    px  = PXW'(cmd_q.x0) + PXW'(i);
                    py  = PYW'(cmd_q.y0) + PYW'(r_q);
                    pxm = px[XW-1:0];
                    pym = py[YW-1:0];
                    if (row_dat_q[SPRITE_W-1-i] &&
                        (cmd_q.wrap || ((px < WIDTH_P) && (py < HEIGHT_P)))) begin
                        if (fb_d[~pym][~pxm]) begin
                            acc_d = 1'b1;
                        end
                        fb_d[~pym][~pxm] = ~fb_d[~pym][~pxm];
                    end
                end
                r_d    = r_q + RW'(1);
                next_y = PYW'(cmd_q.y0) + PYW'(r_d);
                if ((r_d == cmd_q.rows) || (!cmd_q.wrap && (next_y >= HEIGHT_P))) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_CLEAR: begin
                fb_d[~clr_row_q] = '0;
                if (clr_row_q == LAST_ROW) begin
                    state_d = S_DONE;
                end else begin
                    clr_row_d = clr_row_q + YW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Publish collision on entry to DONE so it is valid alongside done.
        if (state_d == S_DONE) begin
            collision_d = (state_q == S_CLEAR) ? 1'b0 : acc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            r_q         <= '0;
            clr_row_q   <= '0;
            row_dat_q   <= '0;
            acc_q       <= 1'b0;
            collision_q <= 1'b0;
            fb_q        <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            r_q         <= r_d;
            clr_row_q   <= clr_row_d;
            row_dat_q   <= row_dat_d;
            acc_q       <= acc_d;
            collision_q <= collision_d;
            fb_q        <= fb_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign row_req   = (state_q == S_FETCH);
    assign row_index = r_q[IW-1:0];
    assign done      = (state_q == S_DONE);
    assign collision = collision_q;
    assign display   = fb_q;

endmodule

// File: tb/tb_chip8_sprite_blitter.sv
// Self-checking bench for chip8_sprite_blitter: directed plus randomized draws/clears against a pixel-array model.
module tb_chip8_sprite_blitter;

    localparam int W  = 64;
    localparam int H  = 32;
    localparam int SW = 8;
    localparam int MR = 16;
    localparam int WH = W * H;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int RW = $clog2(MR) + 1;
    localparam int IW = $clog2(MR);

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [XW-1:0]     cmd_x;
    logic [YW-1:0]     cmd_y;
    logic [RW-1:0]     cmd_rows;
    logic              wrap_mode;
    logic              row_req;
    logic [IW-1:0]     row_index;
    logic [SW-1:0]     row_data;
    logic              row_valid;
    logic              busy;
    logic              done;
    logic              collision;
    logic [WH-1:0]     display;

    chip8_sprite_blitter #(.WIDTH(W), .HEIGHT(H), .SPRITE_W(SW), .MAX_ROWS(MR)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_rows  (cmd_rows),
        .wrap_mode (wrap_mode),
        .row_req   (row_req),
        .row_index (row_index),
        .row_data  (row_data),
        .row_valid (row_valid),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .display   (display)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    bit          mdl [H][W];
    logic [7:0]  spr [MR];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                mdl[y][x] = 1'b0;
    endfunction

    // Whole-sprite semantics: rows fetched in order, clipped rows below the
    // screen stop the command, clipped columns are simply lost.
    function automatic void model_draw(input int x0, input int y0, input int rows, input bit wrap,
                                       output int nf, output bit coll);
        nf   = 0;
        coll = 1'b0;
        for (int r = 0; r < rows; r++) begin
            if (!wrap && (y0 + r >= H)) break;
            nf++;
            for (int i = 0; i < SW; i++) begin
                int px, py;
                if (!spr[r][SW-1-i]) continue;
                px = x0 + i;
                py = y0 + r;
                if (wrap) begin
                    px = px % W;
                    py = py % H;
                end else if (px >= W) begin
                    continue;
                end
                if (mdl[py][px]) coll = 1'b1;
                mdl[py][px] = ~mdl[py][px];
            end
        end
    endfunction

    function automatic logic [WH-1:0] model_vec();
        logic [WH-1:0] v;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                v[WH-1-(y*W+x)] = mdl[y][x];
        return v;
    endfunction

    task automatic check_display(input string tag);
        logic [WH-1:0] e;
        int nd, first;
        e     = model_vec();
        nd    = 0;
        first = 0;
        for (int k = WH - 1; k >= 0; k--) begin
            if (display[k] !== e[k]) begin
                if (nd == 0) first = k;
                nd++;
            end
        end
        n_total++;
        assert (display === e) n_pass++;
        else $error("FAIL %s display: %0d bits differ, first at bit %0d observed %0b expected %0b",
                    tag, nd, first, display[first], e[first]);
    endtask

    task automatic run_draw(input int x, input int y, input int rows, input bit wrap,
                            input int stall, input string tag);
        int exp_nf, cyc, nf, wc;
        bit exp_coll, seen;
        model_draw(x, y, rows, wrap, exp_nf, exp_coll);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_x     = XW'(x);
        cmd_y     = YW'(y);
        cmd_rows  = RW'(rows);
        wrap_mode = wrap;
        check({tag, ":ready"}, cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cyc  = 0;
        nf   = 0;
        wc   = 0;
        seen = 1'b0;
        while (cyc < 400 && !seen) begin
            @(negedge clk);
            cyc++;
            row_valid = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else if (row_req) begin
                if (wc == 0) check({tag, ":row_index"}, row_index, nf);
                if (wc >= stall) begin
                    row_valid = 1'b1;
                    row_data  = spr[row_index];
                    nf++;
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
        check({tag, ":done_seen"}, seen, 1);
        if (stall == 0) check({tag, ":latency"}, cyc, 2 * exp_nf + 1);
        check({tag, ":fetches"}, nf, exp_nf);
        check({tag, ":collision"}, collision, exp_coll);
        check_display(tag);
        @(negedge clk);
        check({tag, ":done_pulse"}, done, 0);
        check({tag, ":coll_held"}, collision, exp_coll);
    endtask

    task automatic run_clear(input string tag);
        int cyc;
        bit seen;
        model_clear();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_rows  = '0;
        check({tag, ":ready"}, cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 400 && !seen) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        check({tag, ":done_seen"}, seen, 1);
        check({tag, ":latency"}, cyc, H + 1);
        check({tag, ":collision"}, collision, 0);
        check_display(tag);
    endtask

    initial begin
        logic [63:0] row0;
        int nf, wc, dummy_nf;
        bit dummy_c;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_rows  = '0;
        wrap_mode = 1'b0;
        row_data  = '0;
        row_valid = 1'b0;
        for (int i = 0; i < MR; i++) spr[i] = 8'h00;
        model_clear();

        repeat (3) @(negedge clk);
        check("rst:busy", busy, 0);
        check("rst:cmd_ready", cmd_ready, 1);
        check("rst:done", done, 0);
        check("rst:row_req", row_req, 0);
        check("rst:row_index", row_index, 0);
        check("rst:collision", collision, 0);
        check_display("rst");
        reset = 1'b1;

        spr[0] = 8'hF0;
        run_draw(0, 0, 1, 1'b0, 0, "first");
        check("first:byte", display[WH-1 -: 8], 8'hF0);
        run_draw(0, 0, 1, 1'b0, 0, "erase");
        check("erase:byte", display[WH-1 -: 8], 8'h00);
        check("erase:coll", collision, 1);

        spr[0] = 8'hFF;
        run_draw(60, 0, 1, 1'b0, 0, "clipx");
        row0 = display[WH-1 -: 64];
        check("clipx:row0", row0, 64'h0000_0000_0000_000F);
        run_clear("clr1");
        run_draw(60, 0, 1, 1'b1, 0, "wrapx");
        row0 = display[WH-1 -: 64];
        check("wrapx:row0", row0, 64'hF000_0000_0000_000F);

        for (int i = 0; i < 5; i++) spr[i] = 8'($urandom_range(1, 255));
        run_draw(5, 30, 5, 1'b0, 0, "clipy");

        for (int i = 0; i < MR; i++) spr[i] = 8'hFF;
        run_clear("clr2");
        for (int y = 0; y < H; y += 16)
            for (int x = 0; x < W; x += 8)
                run_draw(x, y, 16, 1'b0, 0, "fill");
        check("fill:all_ones", (display === {WH{1'b1}}), 1);
        run_clear("clr3");
        check("clr3:all_zero", (display === {WH{1'b0}}), 1);

        for (int t = 0; t < 40; t++) begin
            if (t % 9 == 8) begin
                run_clear("rnd_clr");
            end else begin
                for (int i = 0; i < MR; i++) spr[i] = 8'($urandom_range(0, 255));
                run_draw(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
                         int'($urandom_range(0, MR)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 2)), "rnd");
            end
        end

        run_clear("clr4");
        for (int i = 0; i < MR; i++) spr[i] = 8'($urandom_range(1, 255));
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_x     = XW'(10);
        cmd_y     = YW'(5);
        cmd_rows  = RW'(4);
        wrap_mode = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        nf = 0;
        wc = 0;
        for (int c = 0; c < 200 && nf < 2; c++) begin
            @(negedge clk);
            row_valid = 1'b0;
            if (row_req) begin
                if (wc >= 3) begin
                    row_valid = 1'b1;
                    row_data  = spr[row_index];
                    nf++;
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
        check("abort:two_rows", nf, 2);
        @(negedge clk);
        row_valid = 1'b0;
        @(negedge clk);
        check("abort:in_fetch", row_req, 1);
        check("abort:row_index", row_index, 2);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        check("abort:ready_busy", cmd_ready, 0);
        @(negedge clk);
        check("abort:cmd_ignored", row_req, 1);
        check("abort:busy", busy, 1);
        model_draw(10, 5, 2, 1'b0, dummy_nf, dummy_c);
        check_display("abort:partial");
        reset = 1'b0;
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        model_clear();
        check("abort:row_req", row_req, 0);
        check("abort:busy_low", busy, 0);
        check("abort:cmd_ready", cmd_ready, 1);
        check_display("abort:cleared");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort:no_done", done, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort:post_done", done, 0);
        check("abort:post_busy", busy, 0);
        check("abort:post_coll", collision, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
